cache_data_bank: RTL and testbench

- Parametrised N-way cache data bank: one simple-dual-port block RAM per way, all ways read in parallel on one index, byte-masked writes to one selected way.
- Forwards same-cycle write/read collisions, so a read always returns data that includes writes issued in the same cycle.
- After reset, a state machine zero-fills every line of every way; `init_busy` flags the sweep.
- Used by both I- and D-cache as the line storage behind the tag compare stage.

---
 rtl/cache_data_bank_if.sv | 31 +++
 rtl/cache_data_bank.sv | 194 +++++++++++++++++++
 tb/tb_cache_data_bank.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_data_bank_if.sv
// Bus bundle for cache_data_bank.
// Ports (master drives, slave receives):
//   ren, rindex              read launch and set index
//   rvalid, rdata            read result, way w at [w*LINE_W +: LINE_W]
//   wway, wen, windex, wdata one-hot way select, byte mask, index, data
//   init_busy                zero-fill sweep in progress
interface cache_data_bank_if #(
  parameter int WAYS    = 2,
  parameter int INDEX_W = 7,
  parameter int LINE_W  = 256
);
  logic                     init_busy;
  logic                     ren;
  logic [INDEX_W-1:0]       rindex;
  logic                     rvalid;
  logic [WAYS*LINE_W-1:0]   rdata;
  logic [WAYS-1:0]          wway;
  logic [LINE_W/8-1:0]      wen;
  logic [INDEX_W-1:0]       windex;
  logic [LINE_W-1:0]        wdata;

  modport master (
    output ren, rindex, wway, wen, windex, wdata,
    input  init_busy, rvalid, rdata
  );

  modport slave (
    input  ren, rindex, wway, wen, windex, wdata,
    output init_busy, rvalid, rdata
  );
endinterface

// File: rtl/cache_data_bank.sv
// N-way cache data bank: one simple-dual-port block RAM per way, all ways
// read in parallel, byte-masked writes into one way, same-cycle write/read
// collisions forwarded into the read result. Every line is zero-filled
// after reset.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   cache_data_bank_if.slave (read/write bus and init_busy)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | zero-fill sweep, line cnt of all ways written each cycle
// ST_RUN  | normal operation, external reads and writes accepted
module cache_data_bank #(
  parameter int WAYS     = 2,
  parameter int INDEX_W  = 7,
  parameter int LINE_W   = 256,
  parameter int READ_LAT = 1
) (
  input logic             clk,
  input logic             rst,
  cache_data_bank_if.slave bus
);
  localparam int DEPTH = 1 << INDEX_W;
  localparam int NB    = LINE_W / 8;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
    $error("cache_data_bank: READ_LAT must be 1 or 2");
  end
  if ((LINE_W % 8) != 0) begin : g_bad_line
    $error("cache_data_bank: LINE_W must be a multiple of 8");
  end
  if (WAYS < 1 || WAYS > 8) begin : g_bad_ways
    $error("cache_data_bank: WAYS must be 1..8");
  end

  logic [0:0]         state_q, state_d;
  logic [INDEX_W-1:0] cnt_q, cnt_d;
  logic               run, ren_eff, wr_active, coll;
  logic [INDEX_W-1:0] ram_waddr;
  logic [LINE_W-1:0]  ram_wdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + INDEX_W'(1);
      if (cnt_q == '1) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign run           = (state_q == ST_RUN);
  assign bus.init_busy = ~run;
  assign ren_eff       = run & bus.ren;
  assign wr_active     = run & (|bus.wway) & (|bus.wen);
  assign coll          = ren_eff & (bus.rindex == bus.windex) & wr_active;
  assign ram_waddr     = run ? bus.windex : cnt_q;
  assign ram_wdata     = run ? bus.wdata : '0;

  // Shared read-valid and forwarded-data pipeline. Forward data is only
  // captured on a read launch so the output holds between reads.
  logic              rvld1_q, rvld1_d;
  logic [LINE_W-1:0] fdata1_q, fdata1_d;
  logic [LINE_W-1:0] fdata_out;

  always_comb begin
    rvld1_d  = ren_eff;
    fdata1_d = ren_eff ? bus.wdata : fdata1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvld1_q  <= 1'b0;
      fdata1_q <= '0;
    end else begin
      rvld1_q  <= rvld1_d;
      fdata1_q <= fdata1_d;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic              rvld2_q, rvld2_d;
    logic [LINE_W-1:0] fdata2_q, fdata2_d;

    always_comb begin
      rvld2_d  = rvld1_q;
      fdata2_d = rvld1_q ? fdata1_q : fdata2_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rvld2_q  <= 1'b0;
        fdata2_q <= '0;
      end else begin
        rvld2_q  <= rvld2_d;
        fdata2_q <= fdata2_d;
      end
    end

    assign bus.rvalid = rvld2_q;
    assign fdata_out  = fdata2_q;
  end else begin : g_lat1
    assign bus.rvalid = rvld1_q;
    assign fdata_out  = fdata1_q;
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic [NB-1:0]     we;
    logic [LINE_W-1:0] ram [DEPTH];
    logic [LINE_W-1:0] dout1_q, dout1_d;
    logic [NB-1:0]     fmask1_q, fmask1_d;
    logic [LINE_W-1:0] dout_out;
    logic [NB-1:0]     fmask_out;
    logic [LINE_W-1:0] merged;

    // During the sweep every byte of every way is written with zero.
    assign we = run ? (bus.wen & {NB{bus.wway[w]}}) : '1;

    always_ff @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
        if (we[b]) ram[ram_waddr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end

    // Read-first port: a same-cycle write is not seen here, the forward
    // mask patches it in at the output.
    always_comb begin
      dout1_d  = dout1_q;
      fmask1_d = fmask1_q;
      if (ren_eff) begin
        dout1_d  = ram[bus.rindex];
        fmask1_d = coll ? we : '0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        dout1_q  <= '0;
        fmask1_q <= '0;
      end else begin
        dout1_q  <= dout1_d;
        fmask1_q <= fmask1_d;
      end
    end

    if (READ_LAT == 2) begin : g_s2
      logic [LINE_W-1:0] dout2_q, dout2_d;
      logic [NB-1:0]     fmask2_q, fmask2_d;

      always_comb begin
        dout2_d  = rvld1_q ? dout1_q  : dout2_q;
        fmask2_d = rvld1_q ? fmask1_q : fmask2_q;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          dout2_q  <= '0;
          fmask2_q <= '0;
        end else begin
          dout2_q  <= dout2_d;
          fmask2_q <= fmask2_d;
        end
      end

      assign dout_out  = dout2_q;
      assign fmask_out = fmask2_q;
    end else begin : g_s1
      assign dout_out  = dout1_q;
      assign fmask_out = fmask1_q;
    end

    always_comb begin
      merged = dout_out;
      for (int b = 0; b < NB; b++) begin
        if (fmask_out[b]) merged[8*b +: 8] = fdata_out[8*b +: 8];
      end
    end

    assign bus.rdata[w*LINE_W +: LINE_W] = merged;
  end
endmodule

// File: tb/tb_cache_data_bank.sv
// Directed bench for cache_data_bank: one READ_LAT=1 and one READ_LAT=2
// instance driven with identical stimulus.
module tb_cache_data_bank;
  localparam int WAYS    = 2;
  localparam int INDEX_W = 7;
  localparam int LINE_W  = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                ren;
  logic [INDEX_W-1:0]  rindex;
  logic [WAYS-1:0]     wway;
  logic [LINE_W/8-1:0] wen;
  logic [INDEX_W-1:0]  windex;
  logic [LINE_W-1:0]   wdata;

  int tests_run    = 0;
  int tests_failed = 0;

  cache_data_bank_if #(.WAYS(WAYS), .INDEX_W(INDEX_W), .LINE_W(LINE_W)) bus1 ();
  cache_data_bank_if #(.WAYS(WAYS), .INDEX_W(INDEX_W), .LINE_W(LINE_W)) bus2 ();

  assign bus1.ren = ren;   assign bus2.ren = ren;
  assign bus1.rindex = rindex; assign bus2.rindex = rindex;
  assign bus1.wway = wway; assign bus2.wway = wway;
  assign bus1.wen = wen;   assign bus2.wen = wen;
  assign bus1.windex = windex; assign bus2.windex = windex;
  assign bus1.wdata = wdata; assign bus2.wdata = wdata;

  cache_data_bank #(.WAYS(WAYS), .INDEX_W(INDEX_W), .LINE_W(LINE_W), .READ_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));
  cache_data_bank #(.WAYS(WAYS), .INDEX_W(INDEX_W), .LINE_W(LINE_W), .READ_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave));

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    ren  = 1'b0;
    wway = '0;
    wen  = '0;
  endtask

  task automatic test_reset;
    int n, bad;
    rst = 1'b1; idle(); rindex = '0; windex = '0; wdata = '0;
    cyc(); cyc();
    rst = 1'b0;
    tests_run++;
    if (bus1.init_busy !== 1'b1 || bus2.init_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_busy: got %b/%b want 1/1", bus1.init_busy, bus2.init_busy);
    end
    tests_run++;
    if (bus1.rvalid !== 1'b0 || bus2.rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_rvalid: got %b/%b want 0/0", bus1.rvalid, bus2.rvalid);
    end
    tests_run++;
    if (bus1.rdata !== '0 || bus2.rdata !== '0) begin
      tests_failed++;
      $display("FAIL reset_rdata: got %h want 0", bus1.rdata | bus2.rdata);
    end
    ren = 1'b1; rindex = 7'd0;
    n = 0; bad = 0;
    while (bus1.init_busy === 1'b1 && n < 400) begin
      if (bus1.rvalid !== 1'b0 || bus2.rvalid !== 1'b0) bad++;
      n++;
      cyc();
    end
    ren = 1'b0;
    tests_run++;
    if (n != 128) begin
      tests_failed++;
      $display("FAIL sweep_length: got %0d cycles want 128", n);
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL sweep_rvalid: got %0d cycles with rvalid want 0", bad);
    end
    tests_run++;
    if (bus2.init_busy !== 1'b0 || bus1.rvalid !== 1'b0 || bus2.rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL sweep_end: got busy2=%b rvalid=%b/%b want 0 0/0",
               bus2.init_busy, bus1.rvalid, bus2.rvalid);
    end
    ren = 1'b1; rindex = 7'd0;
    cyc();
    rindex = 7'd127;
    tests_run++;
    if (bus1.rvalid !== 1'b1 || bus1.rdata !== '0) begin
      tests_failed++;
      $display("FAIL zero_idx0_lat1: got v=%b %h want v=1 0", bus1.rvalid, bus1.rdata);
    end
    cyc();
    ren = 1'b0;
    tests_run++;
    if (bus1.rvalid !== 1'b1 || bus1.rdata !== '0 || bus2.rvalid !== 1'b1 || bus2.rdata !== '0) begin
      tests_failed++;
      $display("FAIL zero_idx127_lat1_idx0_lat2: got v=%b/%b %h %h want v=1/1 0 0",
               bus1.rvalid, bus2.rvalid, bus1.rdata, bus2.rdata);
    end
    cyc();
    tests_run++;
    if (bus2.rvalid !== 1'b1 || bus2.rdata !== '0) begin
      tests_failed++;
      $display("FAIL zero_idx127_lat2: got v=%b %h want v=1 0", bus2.rvalid, bus2.rdata);
    end
  endtask

  task automatic test_basic;
    logic [2*LINE_W-1:0] exp;
    exp = {{32{8'hA5}}, 256'h0};
    wway = 2'b10; wen = '1; windex = 7'd5; wdata = {32{8'hA5}};
    cyc();
    idle();
    cyc();
    ren = 1'b1; rindex = 7'd5;
    cyc();
    ren = 1'b0;
    tests_run++;
    if (bus1.rvalid !== 1'b1 || bus1.rdata !== exp) begin
      tests_failed++;
      $display("FAIL basic_lat1: got v=%b %h want v=1 %h", bus1.rvalid, bus1.rdata, exp);
    end
    tests_run++;
    if (bus2.rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_lat2_early: got v=%b want 0", bus2.rvalid);
    end
    cyc();
    tests_run++;
    if (bus2.rvalid !== 1'b1 || bus2.rdata !== exp || bus1.rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_lat2: got v=%b %h v1=%b want v=1 %h v1=0",
               bus2.rvalid, bus2.rdata, bus1.rvalid, exp);
    end
  endtask

  task automatic test_collision;
    logic [2*LINE_W-1:0] exp;
    exp = {256'h0, {28{8'h11}}, {4{8'hFF}}};
    wway = 2'b01; wen = '1; windex = 7'd9; wdata = {32{8'h11}};
    cyc();
    idle();
    cyc();
    wway = 2'b01; wen = 32'h0000000F; windex = 7'd9;
    wdata = {{28{8'hEE}}, {4{8'hFF}}};
    ren = 1'b1; rindex = 7'd9;
    cyc();
    idle();
    tests_run++;
    if (bus1.rvalid !== 1'b1 || bus1.rdata !== exp) begin
      tests_failed++;
      $display("FAIL collision_lat1: got v=%b %h want v=1 %h", bus1.rvalid, bus1.rdata, exp);
    end
    cyc();
    tests_run++;
    if (bus2.rvalid !== 1'b1 || bus2.rdata !== exp) begin
      tests_failed++;
      $display("FAIL collision_lat2: got v=%b %h want v=1 %h", bus2.rvalid, bus2.rdata, exp);
    end
    ren = 1'b1; rindex = 7'd9;
    cyc();
    ren = 1'b0;
    tests_run++;
    if (bus1.rdata !== exp) begin
      tests_failed++;
      $display("FAIL collision_ram_lat1: got %h want %h", bus1.rdata, exp);
    end
    cyc();
    tests_run++;
    if (bus2.rdata !== exp) begin
      tests_failed++;
      $display("FAIL collision_ram_lat2: got %h want %h", bus2.rdata, exp);
    end
  endtask

  task automatic test_diff_index;
    logic [2*LINE_W-1:0] exp;
    exp = {{32{8'hA5}}, 256'h0};
    wway = 2'b10; wen = '1; windex = 7'd7; wdata = {32{8'h5A}};
    ren = 1'b1; rindex = 7'd5;
    cyc();
    idle();
    tests_run++;
    if (bus1.rvalid !== 1'b1 || bus1.rdata !== exp) begin
      tests_failed++;
      $display("FAIL diff_index_lat1: got v=%b %h want v=1 %h", bus1.rvalid, bus1.rdata, exp);
    end
    cyc();
    tests_run++;
    if (bus2.rvalid !== 1'b1 || bus2.rdata !== exp) begin
      tests_failed++;
      $display("FAIL diff_index_lat2: got v=%b %h want v=1 %h", bus2.rvalid, bus2.rdata, exp);
    end
  endtask

  task automatic test_later_write;
    logic [2*LINE_W-1:0] e22, e33;
    e22 = {256'h0, {32{8'h22}}};
    e33 = {256'h0, {32{8'h33}}};
    wway = 2'b01; wen = '1; windex = 7'd3; wdata = {32{8'h22}};
    cyc();
    idle();
    cyc();
    ren = 1'b1; rindex = 7'd3;
    cyc();
    ren = 1'b0;
    wway = 2'b01; wen = '1; windex = 7'd3; wdata = {32{8'h33}};
    tests_run++;
    if (bus1.rvalid !== 1'b1 || bus1.rdata !== e22) begin
      tests_failed++;
      $display("FAIL later_write_lat1: got v=%b %h want v=1 %h", bus1.rvalid, bus1.rdata, e22);
    end
    cyc();
    idle();
    ren = 1'b1; rindex = 7'd3;
    tests_run++;
    if (bus2.rvalid !== 1'b1 || bus2.rdata !== e22) begin
      tests_failed++;
      $display("FAIL later_write_lat2: got v=%b %h want v=1 %h", bus2.rvalid, bus2.rdata, e22);
    end
    cyc();
    ren = 1'b0;
    tests_run++;
    if (bus1.rvalid !== 1'b1 || bus1.rdata !== e33) begin
      tests_failed++;
      $display("FAIL reread_lat1: got v=%b %h want v=1 %h", bus1.rvalid, bus1.rdata, e33);
    end
    cyc();
    tests_run++;
    if (bus2.rvalid !== 1'b1 || bus2.rdata !== e33) begin
      tests_failed++;
      $display("FAIL reread_lat2: got v=%b %h want v=1 %h", bus2.rvalid, bus2.rdata, e33);
    end
  endtask

  task automatic test_hold;
    logic [2*LINE_W-1:0] e33;
    e33 = {256'h0, {32{8'h33}}};
    idle();
    for (int i = 0; i < 4; i++) begin
      cyc();
      tests_run++;
      if (bus1.rvalid !== 1'b0 || bus2.rvalid !== 1'b0 || bus1.rdata !== e33 || bus2.rdata !== e33) begin
        tests_failed++;
        $display("FAIL hold_%0d: got v=%b/%b %h %h want v=0/0 %h",
                 i, bus1.rvalid, bus2.rvalid, bus1.rdata, bus2.rdata, e33);
      end
    end
  endtask

  task automatic test_mid_reset;
    int n;
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 1; i < 60; i++) cyc();
    tests_run++;
    if (bus1.init_busy !== 1'b1 || bus2.init_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_sweep_busy: got %b/%b want 1/1", bus1.init_busy, bus2.init_busy);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n = 0;
    while (bus1.init_busy === 1'b1 && n < 400) begin
      if (n == 100) begin
        wway = 2'b11; wen = '1; windex = 7'd5; wdata = {32{8'hFF}};
      end else begin
        idle();
      end
      n++;
      cyc();
    end
    idle();
    tests_run++;
    if (n != 128) begin
      tests_failed++;
      $display("FAIL restart_length: got %0d cycles want 128", n);
    end
    ren = 1'b1; rindex = 7'd5;
    cyc();
    rindex = 7'd9;
    tests_run++;
    if (bus1.rvalid !== 1'b1 || bus1.rdata !== '0) begin
      tests_failed++;
      $display("FAIL ignored_write_lat1: got v=%b %h want v=1 0", bus1.rvalid, bus1.rdata);
    end
    cyc();
    ren = 1'b0;
    tests_run++;
    if (bus1.rdata !== '0 || bus2.rvalid !== 1'b1 || bus2.rdata !== '0) begin
      tests_failed++;
      $display("FAIL resweep_idx9_lat1_idx5_lat2: got %h v2=%b %h want 0 v2=1 0",
               bus1.rdata, bus2.rvalid, bus2.rdata);
    end
    cyc();
    tests_run++;
    if (bus2.rdata !== '0) begin
      tests_failed++;
      $display("FAIL resweep_idx9_lat2: got %h want 0", bus2.rdata);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_collision();
    test_diff_index();
    test_later_write();
    test_hold();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
